multu: RTL and testbench

Unsigned 32×32 iterative shift-add multiplier producing a 64-bit product, used by the CPU datapath for the MULTU instruction (HI/LO write-back). There is no start strobe. The block starts a multiplication on its own whenever the operand pair differs from the pair it last computed. It asserts `busy` while iterating and holds the last completed product on `result`.

---
 rtl/multu.sv | 112 +++++++++++
 tb/tb_multu.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/multu.sv
// Unsigned 32x32 iterative shift-add multiplier that starts by itself whenever the operand pair changes.
// Optional MULTU_EARLY_TERM_EN finishes as soon as the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | compare operands against last pair, start on change (or first cycle after reset)
// RUN   | one shift-add iteration per cycle, busy high
module multu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [63:0] result
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [31:0] last_a_q, last_a_d;
  logic [31:0] last_b_q, last_b_d;
  logic        seen_q, seen_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        busy_q, busy_d;

  logic [63:0] acc_sum;
  logic [31:0] mplier_sh;
  logic        last_iter;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_a_q <= '0;
      last_b_q <= '0;
      seen_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_a_q <= last_a_d;
      last_b_q <= last_b_d;
      seen_q   <= seen_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      busy_q   <= busy_d;
    end
  end

  assign acc_sum   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_sh = mplier_q >> 1;
`ifdef MULTU_EARLY_TERM_EN
  assign last_iter = (cnt_q == 6'd31) || (mplier_sh == 32'd0);
`else
  assign last_iter = (cnt_q == 6'd31);
`endif

  always_comb begin
    state_d  = state_q;
    last_a_d = last_a_q;
    last_b_d = last_b_q;
    seen_d   = seen_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (!seen_q || (a != last_a_q) || (b != last_b_q)) begin
          mcand_d  = {32'b0, a};
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          last_a_d = a;
          last_b_d = b;
          seen_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q + 6'd1;
        if (last_iter) begin
          result_d = acc_sum;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = busy_q;
    result = result_q;
  end

endmodule

// File: tb/tb_multu.sv
// Directed-vector bench for multu: latency, product values, operand-change and reset behaviour.
// Honors MULTU_EARLY_TERM_EN when computing the expected busy width.
module tb_multu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        busy;
  logic [63:0] result;

  int nvec = 0;
  int nerr = 0;

  multu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cycles(input logic [31:0] bv);
`ifdef MULTU_EARLY_TERM_EN
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
    return n;
`else
    return 32;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // counts busy samples from now until busy falls; checks result is frozen meanwhile
  task automatic wait_idle(input logic [63:0] res0, output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    while (busy === 1'b1 && n < 200) begin
      n++;
      if (result !== res0) stable = 1'b0;
      step();
    end
    if (n >= 200) chk_val("timeout", 64'(n), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] exp_res);
    logic [63:0] res0;
    int n;
    bit stable;
    a = av;
    b = bv;
    res0 = result;
    step();
    chk_val({tag, "_busy_rise"}, 64'(busy), 64'd1);
    wait_idle(res0, n, stable);
    chk_val({tag, "_busy_cycles"}, 64'(n), 64'(exp_cycles(bv)));
    chk_val({tag, "_stable"}, 64'(stable), 64'd1);
    chk_val({tag, "_result"}, result, exp_res);
  endtask

  initial begin
    int n, chg;
    bit stable;
    logic [63:0] r0;

    rst_n = 1'b0;
    a = 32'd5;
    b = 32'd5;
    repeat (3) step();
    chk_val("rst_busy", 64'(busy), 64'd0);
    chk_val("rst_result", result, 64'd0);
    rst_n = 1'b1;
    run_op("first", 32'd5, 32'd5, 64'd25);

    repeat (5) step();
    chk_val("hold_busy", 64'(busy), 64'd0);
    chk_val("hold_result", result, 64'd25);

    run_op("ff_x3", 32'hFFFF_FFFF, 32'd3, 64'h0000_0002_FFFF_FFFD);
    repeat (8) step();
    chk_val("ff_x3_hold_busy", 64'(busy), 64'd0);
    chk_val("ff_x3_hold_res", result, 64'h0000_0002_FFFF_FFFD);

    run_op("fe_x7", 32'hFFFF_FFFE, 32'd7, 64'h0000_0006_FFFF_FFF2);
    repeat (8) step();
    run_op("55_x3", 32'd55, 32'd3, 64'h0000_0000_0000_00A5);
    repeat (8) step();
    run_op("fe_x9", 32'hFFFF_FFFE, 32'd9, 64'h0000_0008_FFFF_FFEE);
    repeat (8) step();
    run_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    run_op("zero_a", 32'd0, 32'h1234, 64'd0);
    run_op("msb_b", 32'h1234_5678, 32'h8000_0000, 64'h091A_2B3C_0000_0000);

    // operand change while the first product is still iterating
    chg = (exp_cycles(32'd3) > 10) ? 10 : 1;
    a = 32'hFFFF_FFFF;
    b = 32'd3;
    r0 = result;
    step();
    chk_val("mid_busy_rise", 64'(busy), 64'd1);
    repeat (chg) step();
    a = 32'd55;
    b = 32'd3;
    wait_idle(r0, n, stable);
    chk_val("mid_first_cycles", 64'(n + chg), 64'(exp_cycles(32'd3)));
    chk_val("mid_first_result", result, 64'h0000_0002_FFFF_FFFD);
    step();
    chk_val("mid_restart_busy", 64'(busy), 64'd1);
    wait_idle(64'h0000_0002_FFFF_FFFD, n, stable);
    chk_val("mid_second_cycles", 64'(n), 64'(exp_cycles(32'd3)));
    chk_val("mid_second_stable", 64'(stable), 64'd1);
    chk_val("mid_second_result", result, 64'h0000_0000_0000_00A5);

    // synchronous reset in the middle of a run
    a = 32'h1234_5678;
    b = 32'h8000_0001;
    step();
    chk_val("rst_mid_busy_rise", 64'(busy), 64'd1);
    repeat (14) step();
    chk_val("rst_mid_still_busy", 64'(busy), 64'd1);
    chk_val("rst_mid_res_held", result, 64'h0000_0000_0000_00A5);
    rst_n = 1'b0;
    step();
    chk_val("rst_mid_busy", 64'(busy), 64'd0);
    chk_val("rst_mid_result", result, 64'd0);
    step();
    rst_n = 1'b1;
    run_op("after_rst", 32'h1234_5678, 32'h8000_0001, 64'h091A_2B3C_1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
